game_round_ctrl: RTL and testbench
==================================

Name: game_round_ctrl

Overview:
- Round sequencer for the robot/dragon game.
- Gates player move commands into the robot mover and detects robot–dragon collisions and goal arrival.
- Issues the one-cycle death/kill Event pulses, counts lives, and times respawn cooldown and post-respawn invulnerability.
- Sits between the keyboard decoder and the robot mover; consumes mover and dragon positions.

Parameters:
- LIVES, 3: lives per round, range 1..7.
- RESPAWN_TICKS, 102: clk_22 cycles held in DEAD. Must cover the mover's respawn cooldown.
- INVULN_TICKS, 50: clk_22 cycles after respawn during which collisions are ignored.
- HIT_SIZE, 20: overlap threshold in pixels, per axis.
- GOAL_X, 80: goal x coordinate.
- GOAL_Y, 420: goal y coordinate.

Ports:
- clk_22  in  1  system clock (22-bit divider tick clock)
- rst  in  1  reset, synchronous, active-low
- start  in  1  single-cycle pulse; begins a round from IDLE/GAME_OVER/WIN
- key_opr  in  4  raw move request {up,down,left,right}
- r_x, r_y  in  10 each  robot position
- show_valid  in  1  robot alive flag from mover
- d_x, d_y  in  10 each  dragon position
- hazard  in  1  external hit (e.g. fireball); level
- move_opr  out  4  command to mover
- Event  out  2  bit1 = dragon dies, bit0 = robot dies; one-cycle pulses
- lives  out  3  remaining lives
- state  out  3  FSM state code
- game_over  out  1  high in GAME_OVER
- win  out  1  high in WIN

Behaviour:
- Clocking and reset: all logic on posedge clk_22. Reset is synchronous and active-low: only on an edge with rst=0.
- Reset values: state=IDLE, move_opr=0, Event=0, lives=LIVES, game_over=0, win=0, cooldown counter=0, invuln counter=0.
- State codes: IDLE=0, PLAY=1, DEAD=2, GAME_OVER=3, WIN=4.
- Overlap test: abs(a_x−b_x) < HIT_SIZE AND abs(a_y−b_y) < HIT_SIZE.
  - Unsigned 10-bit operands; abs via compare-then-subtract, no wrap.
  - hit_d = overlap(robot, dragon). hit_g = overlap(robot, goal).
- move_opr is registered: key_opr sampled at cycle t appears at t+1. It equals 0 in every state except PLAY.
- Event is registered and pulses exactly 1 cycle. It is 0 outside the transition cycle.
- IDLE:
  - start -> PLAY; lives<=LIVES; invuln<=0.
- PLAY, priority order:
  1. hit_g -> WIN; Event<=2'b10.
  2. Else if (hit_d | hazard) & show_valid & invuln==0:
     - lives<=lives−1; Event<=2'b01.
     - If lives==1 -> GAME_OVER, else -> DEAD with cooldown<=RESPAWN_TICKS−1.
  3. Else stay. invuln decrements toward 0, saturating.
- Goal arrival beats a simultaneous hit. Hits during invulnerability are ignored entirely: no Event, no lives change.
- DEAD:
  - move_opr=0; cooldown decrements each cycle.
  - At cooldown==0 -> PLAY; invuln<=INVULN_TICKS.
  - Collisions and start are ignored.
  - Total time in DEAD is exactly RESPAWN_TICKS cycles.
- GAME_OVER and WIN:
  - Outputs game_over/win asserted; move_opr=0.
  - start -> PLAY with lives<=LIVES, game_over/win cleared, invuln<=0.
- start in PLAY or DEAD has no effect.
- Reset mid-round (rst=0 at any edge) forces IDLE and reset values that same edge, including cancelling a pending Event.
- Latency: a position sample at cycle t yields Event and the state change at t+1.

Decomposition:
- Shared package game_pkg:
  - State enum codes.
  - Event bit indices (EV_ROBOT=0, EV_DRAGON=1).
  - Direction bit positions of move_opr.
  - START_X/START_Y and GOAL_X/GOAL_Y defaults.
- Sub-module box_overlap: combinational; inputs two 10-bit coordinate pairs plus a threshold parameter; output overlap. Instanced twice, for dragon and for goal.

Test Plan:
1. Reset, then start, then key_opr=4'b0001 held -> move_opr=0001 one cycle later; state=PLAY; lives=3; Event=00 throughout.
2. PLAY with r=(100,140), d=(110,150), show_valid=1 -> next cycle Event=01 for exactly 1 cycle, lives=2, state=DEAD, move_opr=0. Back in PLAY after exactly 102 cycles. Overlap held for 49 further cycles -> no Event. Overlap at cycle 51 -> Event=01.
3. Three separated hits with LIVES=3 -> third hit gives lives=0, state=GAME_OVER, game_over=1. Then start -> PLAY, lives=3, game_over=0.
4. r=(85,415) overlapping goal AND dragon in the same cycle -> Event=10, state=WIN, win=1, lives unchanged.
5. Boundary: |dx|=19 -> hit; |dx|=20 -> no hit. Cases: r_x=0 with d_x=19, and r_x=0 with d_x=20.
6. rst=0 asserted during DEAD mid-cooldown -> next edge state=IDLE, lives=3, move_opr=0, Event=0. rst=0 between edges has no effect until the edge.

Source files
------------

// File: rtl/game_pkg.sv
// ============================================================================
// Module  : game_pkg
// Brief   : Shared state codes, Event bit indices, direction bits and
//           default positions for the robot/dragon round controller.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package game_pkg;

    localparam int COORD_W = 10;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_PLAY      = 3'd1,
        ST_DEAD      = 3'd2,
        ST_GAME_OVER = 3'd3,
        ST_WIN       = 3'd4
    } state_e;

    localparam int EV_ROBOT  = 0;
    localparam int EV_DRAGON = 1;

    // move_opr bit positions, packed {up,down,left,right}
    localparam int DIR_RIGHT = 0;
    localparam int DIR_LEFT  = 1;
    localparam int DIR_DOWN  = 2;
    localparam int DIR_UP    = 3;

    localparam logic [COORD_W-1:0] DEFAULT_START_X = 10'd40;
    localparam logic [COORD_W-1:0] DEFAULT_START_Y = 10'd40;
    localparam logic [COORD_W-1:0] DEFAULT_GOAL_X  = 10'd80;
    localparam logic [COORD_W-1:0] DEFAULT_GOAL_Y  = 10'd420;

endpackage

`default_nettype wire

// File: rtl/box_overlap.sv
// ============================================================================
// Module  : box_overlap
// Brief   : Combinational per-axis proximity test between two points.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module box_overlap
    import game_pkg::*;
#(
    parameter int HIT_SIZE = 20
) (
    input  logic [COORD_W-1:0] a_x_i,
    input  logic [COORD_W-1:0] a_y_i,
    input  logic [COORD_W-1:0] b_x_i,
    input  logic [COORD_W-1:0] b_y_i,
    output logic               overlap_o
);

    localparam logic [COORD_W:0] c_thr = (COORD_W+1)'(HIT_SIZE);

    logic [COORD_W-1:0] w_dx;
    logic [COORD_W-1:0] w_dy;

    // Subtract the smaller from the larger so the distance never wraps.
    assign w_dx = (a_x_i >= b_x_i) ? (a_x_i - b_x_i) : (b_x_i - a_x_i);
    assign w_dy = (a_y_i >= b_y_i) ? (a_y_i - b_y_i) : (b_y_i - a_y_i);

    assign overlap_o = ({1'b0, w_dx} < c_thr) && ({1'b0, w_dy} < c_thr);

endmodule

`default_nettype wire

// File: rtl/game_round_ctrl.sv
// ============================================================================
// Module  : game_round_ctrl
// Brief   : Round sequencer: gates moves, detects hits/goal, counts lives.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module game_round_ctrl
    import game_pkg::*;
#(
    parameter int                 LIVES         = 3,
    parameter int                 RESPAWN_TICKS = 102,
    parameter int                 INVULN_TICKS  = 50,
    parameter int                 HIT_SIZE      = 20,
    parameter logic [COORD_W-1:0] GOAL_X        = DEFAULT_GOAL_X,
    parameter logic [COORD_W-1:0] GOAL_Y        = DEFAULT_GOAL_Y
) (
    input  logic               clk_22,
    input  logic               rst,
    input  logic               start,
    input  logic [3:0]         key_opr,
    input  logic [COORD_W-1:0] r_x,
    input  logic [COORD_W-1:0] r_y,
    input  logic               show_valid,
    input  logic [COORD_W-1:0] d_x,
    input  logic [COORD_W-1:0] d_y,
    input  logic               hazard,
    output logic [3:0]         move_opr,
    output logic [1:0]         Event,
    output logic [2:0]         lives,
    output logic [2:0]         state,
    output logic               game_over,
    output logic               win
);

    localparam int CW = (RESPAWN_TICKS < 2) ? 1 : $clog2(RESPAWN_TICKS);
    localparam int IW = (INVULN_TICKS < 1) ? 1 : $clog2(INVULN_TICKS + 1);

    localparam logic [CW-1:0] c_cool_load = CW'(RESPAWN_TICKS - 1);
    localparam logic [IW-1:0] c_inv_load  = IW'(INVULN_TICKS);
    localparam logic [2:0]    c_lives     = 3'(LIVES);

    state_e        state_q, state_d;
    logic [2:0]    lives_q, lives_d;
    logic [3:0]    move_q,  move_d;
    logic [1:0]    event_q, event_d;
    logic [CW-1:0] cool_q,  cool_d;
    logic [IW-1:0] inv_q,   inv_d;

    logic w_hit_d;
    logic w_hit_g;

    box_overlap #(.HIT_SIZE(HIT_SIZE)) u_hit_dragon (
        .a_x_i     (r_x),
        .a_y_i     (r_y),
        .b_x_i     (d_x),
        .b_y_i     (d_y),
        .overlap_o (w_hit_d)
    );

    box_overlap #(.HIT_SIZE(HIT_SIZE)) u_hit_goal (
        .a_x_i     (r_x),
        .a_y_i     (r_y),
        .b_x_i     (GOAL_X),
        .b_y_i     (GOAL_Y),
        .overlap_o (w_hit_g)
    );

    always_ff @(posedge clk_22) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            lives_q <= c_lives;
            move_q  <= '0;
            event_q <= '0;
            cool_q  <= '0;
            inv_q   <= '0;
        end else begin
            state_q <= state_d;
            lives_q <= lives_d;
            move_q  <= move_d;
            event_q <= event_d;
            cool_q  <= cool_d;
            inv_q   <= inv_d;
        end
    end

    always_comb begin
        state_d = state_q;
        lives_d = lives_q;
        cool_d  = cool_q;
        inv_d   = inv_q;
        event_d = '0;
        case (state_q)
            ST_IDLE, ST_GAME_OVER, ST_WIN: begin
                if (start) begin
                    state_d = ST_PLAY;
                    lives_d = c_lives;
                    inv_d   = '0;
                end
            end
            ST_PLAY: begin
                // Goal arrival takes precedence over a same-cycle hit.
                if (w_hit_g) begin
                    state_d            = ST_WIN;
                    event_d[EV_DRAGON] = 1'b1;
                end else if ((w_hit_d | hazard) & show_valid & (inv_q == '0)) begin
                    lives_d           = lives_q - 3'd1;
                    event_d[EV_ROBOT] = 1'b1;
                    if (lives_q == 3'd1) begin
                        state_d = ST_GAME_OVER;
                    end else begin
                        state_d = ST_DEAD;
                        cool_d  = c_cool_load;
                    end
                end else if (inv_q != '0) begin
                    inv_d = inv_q - IW'(1);
                end
            end
            ST_DEAD: begin
                if (cool_q == '0) begin
                    state_d = ST_PLAY;
                    inv_d   = c_inv_load;
                end else begin
                    cool_d = cool_q - CW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // Registered move follows the state it will be seen alongside.
        move_d = (state_d == ST_PLAY) ? key_opr : 4'd0;
    end

    assign move_opr  = move_q;
    assign Event     = event_q;
    assign lives     = lives_q;
    assign state     = state_q;
    assign game_over = (state_q == ST_GAME_OVER);
    assign win       = (state_q == ST_WIN);

endmodule

`default_nettype wire

// File: tb/tb_game_round_ctrl.sv
// ============================================================================
// Module  : tb_game_round_ctrl
// Brief   : Scoreboard bench for game_round_ctrl with an independent model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_game_round_ctrl;

    localparam int S_IDLE = 0, S_PLAY = 1, S_DEAD = 2, S_OVER = 3, S_WIN = 4;

    typedef struct {
        int st;
        int lv;
        int mv;
        int ev;
        int go;
        int wn;
    } exp_t;

    logic       clk_22 = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] key_opr;
    logic [9:0] r_x, r_y, d_x, d_y;
    logic       show_valid;
    logic       hazard;
    logic [3:0] move_opr;
    logic [1:0] Event;
    logic [2:0] lives;
    logic [2:0] state;
    logic       game_over;
    logic       win;

    int n_checks = 0;
    int n_fail   = 0;

    exp_t sb[$];

    int m_state, m_lives, m_cool, m_inv, m_move, m_ev;

    game_round_ctrl dut (
        .clk_22     (clk_22),
        .rst        (rst),
        .start      (start),
        .key_opr    (key_opr),
        .r_x        (r_x),
        .r_y        (r_y),
        .show_valid (show_valid),
        .d_x        (d_x),
        .d_y        (d_y),
        .hazard     (hazard),
        .move_opr   (move_opr),
        .Event      (Event),
        .lives      (lives),
        .state      (state),
        .game_over  (game_over),
        .win        (win)
    );

    always #5 clk_22 = ~clk_22;

    initial begin
        #2000000;
        $display("FAIL timeout: simulation ran past its time limit");
        $fatal(1, "timeout");
    end

    task automatic check_eq(input string tag, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic int adiff(input int a, input int b);
        return (a > b) ? a - b : b - a;
    endfunction

    function automatic bit near(input int ax, input int ay, input int bx, input int by);
        return (adiff(ax, bx) < 20) && (adiff(ay, by) < 20);
    endfunction

    // Reference behaviour for one rising edge given the currently driven inputs.
    task automatic model_edge(output exp_t e);
        bit hd, hg;
        hd   = near(int'(r_x), int'(r_y), int'(d_x), int'(d_y));
        hg   = near(int'(r_x), int'(r_y), 80, 420);
        m_ev = 0;
        if (rst === 1'b0) begin
            m_state = S_IDLE; m_lives = 3; m_cool = 0; m_inv = 0;
        end else begin
            case (m_state)
                S_IDLE, S_OVER, S_WIN:
                    if (start) begin m_state = S_PLAY; m_lives = 3; m_inv = 0; end
                S_PLAY:
                    if (hg) begin
                        m_state = S_WIN; m_ev = 2;
                    end else if ((hd || hazard) && show_valid && m_inv == 0) begin
                        m_ev    = 1;
                        m_lives = m_lives - 1;
                        m_state = (m_lives == 0) ? S_OVER : S_DEAD;
                        m_cool  = 101;
                    end else if (m_inv > 0) begin
                        m_inv = m_inv - 1;
                    end
                S_DEAD:
                    if (m_cool == 0) begin m_state = S_PLAY; m_inv = 50; end
                    else m_cool = m_cool - 1;
                default: m_state = S_IDLE;
            endcase
        end
        m_move = (m_state == S_PLAY) ? int'(key_opr) : 0;
        e.st = m_state;
        e.lv = m_lives;
        e.mv = m_move;
        e.ev = m_ev;
        e.go = (m_state == S_OVER) ? 1 : 0;
        e.wn = (m_state == S_WIN) ? 1 : 0;
    endtask

    // Called just before a rising edge; returns on the following falling edge.
    task automatic step();
        exp_t e;
        model_edge(e);
        sb.push_back(e);
        @(posedge clk_22);
        #1;
        e = sb.pop_front();
        check_eq("sb_state", int'(state), e.st);
        check_eq("sb_lives", int'(lives), e.lv);
        check_eq("sb_move", int'(move_opr), e.mv);
        check_eq("sb_event", int'(Event), e.ev);
        check_eq("sb_game_over", int'(game_over), e.go);
        check_eq("sb_win", int'(win), e.wn);
        @(negedge clk_22);
    endtask

    task automatic run_until_state(input int target, input int max, output int n);
        n = max + 1;
        for (int i = 1; i <= max; i++) begin
            step();
            if (int'(state) == target) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic run_until_event(input int max, output int n);
        n = max + 1;
        for (int i = 1; i <= max; i++) begin
            step();
            if (Event != 2'b00) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic set_pos(input int rx, input int ry, input int dx, input int dy);
        r_x = 10'(rx); r_y = 10'(ry); d_x = 10'(dx); d_y = 10'(dy);
    endtask

    initial begin
        int n;
        rst = 1'b0; start = 1'b0; key_opr = 4'd0; show_valid = 1'b1; hazard = 1'b0;
        set_pos(300, 300, 500, 100);
        m_state = S_IDLE; m_lives = 3; m_cool = 0; m_inv = 0; m_move = 0; m_ev = 0;
        @(negedge clk_22);
        step();
        step();
        check_eq("reset_state", int'(state), 0);
        check_eq("reset_lives", int'(lives), 3);
        check_eq("reset_move", int'(move_opr), 0);

        // Move gating and start
        rst = 1'b1; key_opr = 4'b0001;
        step();
        check_eq("idle_move_gated", int'(move_opr), 0);
        start = 1'b1; step(); start = 1'b0;
        check_eq("start_play", int'(state), 1);
        check_eq("start_move", int'(move_opr), 1);
        step(); step();

        // Dragon hit, respawn time, invulnerability window
        set_pos(100, 140, 110, 150);
        step();
        check_eq("hit1_event", int'(Event), 1);
        check_eq("hit1_lives", int'(lives), 2);
        check_eq("hit1_state", int'(state), 2);
        set_pos(300, 300, 500, 100);
        step();
        check_eq("hit1_pulse_end", int'(Event), 0);
        run_until_state(S_PLAY, 200, n);
        check_eq("dead_cycles", n + 1, 102);
        set_pos(100, 140, 110, 150);
        run_until_event(100, n);
        check_eq("invuln_cycles", n, 51);
        check_eq("hit2_lives", int'(lives), 1);

        // Final life -> GAME_OVER, then restart
        set_pos(300, 300, 500, 100);
        run_until_state(S_PLAY, 200, n);
        repeat (50) step();
        set_pos(100, 140, 110, 150);
        step();
        check_eq("over_state", int'(state), 3);
        check_eq("over_lives", int'(lives), 0);
        check_eq("over_flag", int'(game_over), 1);
        step();
        start = 1'b1; step(); start = 1'b0;
        check_eq("restart_lives", int'(lives), 3);
        check_eq("restart_flag", int'(game_over), 0);

        // Goal beats a simultaneous dragon hit
        set_pos(85, 415, 90, 420);
        step();
        check_eq("goal_event", int'(Event), 2);
        check_eq("goal_win", int'(win), 1);
        check_eq("goal_lives", int'(lives), 3);
        step();

        // Overlap boundary: 20 misses, 19 hits
        set_pos(0, 200, 20, 200);
        start = 1'b1; step(); start = 1'b0;
        repeat (3) step();
        check_eq("dx20_no_hit", int'(state), 1);
        set_pos(0, 200, 0, 220);
        step();
        check_eq("dy20_no_hit", int'(Event), 0);
        set_pos(0, 200, 19, 200);
        step();
        check_eq("dx19_hit", int'(Event), 1);

        // start ignored in DEAD; rst only takes effect at an edge
        set_pos(300, 300, 500, 100);
        start = 1'b1; hazard = 1'b1;
        repeat (5) step();
        check_eq("dead_ignores_start", int'(state), 2);
        start = 1'b0; hazard = 1'b0;
        repeat (25) step();
        rst = 1'b0;
        #2;
        check_eq("rst_between_edges", int'(state), 2);
        step();
        check_eq("rst_mid_dead_state", int'(state), 0);
        check_eq("rst_mid_dead_lives", int'(lives), 3);

        // Reset on the edge that would produce a hit cancels the Event
        rst = 1'b1; start = 1'b1; step(); start = 1'b0;
        set_pos(100, 140, 110, 150); rst = 1'b0;
        step();
        check_eq("rst_cancels_event", int'(Event), 0);
        rst = 1'b1;

        // Hazard needs show_valid
        set_pos(300, 300, 500, 100);
        start = 1'b1; step(); start = 1'b0;
        hazard = 1'b1; show_valid = 1'b0;
        step();
        check_eq("hazard_invalid", int'(Event), 0);
        show_valid = 1'b1;
        step();
        check_eq("hazard_valid", int'(Event), 1);
        hazard = 1'b0;

        // Randomised traffic against the model
        for (int i = 0; i < 1500; i++) begin
            int bx, by;
            rst        = ($urandom_range(0, 299) != 0);
            start      = ($urandom_range(0, 19) == 0);
            hazard     = ($urandom_range(0, 19) == 0);
            show_valid = ($urandom_range(0, 9) != 0);
            key_opr    = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 9) == 0) begin
                bx = 80; by = 420;
            end else begin
                bx = $urandom_range(30, 990); by = $urandom_range(30, 990);
            end
            set_pos(bx + $urandom_range(0, 50) - 25, by + $urandom_range(0, 50) - 25,
                    bx, by);
            d_x = 10'($urandom_range(0, 1) == 0 ? bx : $urandom_range(0, 1023));
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
